// File: rtl/hex_display_pkg.sv
// Shared types and glyph table for the multiplexed hex display driver.
// Glyphs are active-high, bit order {g,f,e,d,c,b,a}.
package hex_display_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h00;

  // 0-9, then A b C d E F (b and d lowercase so they differ from 8 and 0)
  localparam seg_t GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble to seven-segment decoder, active-high segments.
import hex_display_pkg::*;

module hex_seg_decode (
  input  logic [3:0] nibble,
  output seg_t       seg
);

  always_comb begin
    seg = GLYPHS[nibble];
  end

endmodule

// File: rtl/hex_display_scan.sv
// Time-multiplexed hex display driver: prescaled digit scan, frame-synchronous
// value update, leading-zero blanking, per-digit decimal points.
import hex_display_pkg::*;

module hex_display_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 16,
  parameter int SCAN_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] dp_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int EXT_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  localparam seg_t                  SEG_POL = {7{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{ACTIVE_LOW}};

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]     pending_q, pending_d;
  logic [DATA_W-1:0]     disp_q, disp_d;
  logic                  frame_done_q, frame_done_d;
  seg_t                  seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  tick;
  logic                  wrap;
  logic [EXT_W-1:0]      disp_ext;
  logic [3:0]            cur_nibble;
  logic                  cur_blank;
  logic                  cur_dp;
  logic                  upper_zero;
  logic [NUM_DIGITS-1:0] an_hot;
  seg_t                  glyph;

  // Scan timing and frame-synchronous value transfer
  always_comb begin
    tick      = (cnt_q == CNT_MAX);
    wrap      = tick && (idx_q == IDX_MAX);
    cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    end
    pending_d = load ? data_in : pending_q;
    disp_d    = disp_q;
    if (wrap) begin
      disp_d = load ? data_in : pending_q;
    end
    frame_done_d = wrap;
  end

  // Select the current digit; a digit is a leading zero when it and every
  // digit above it are zero, so scan from the top down.
  always_comb begin
    disp_ext             = '0;
    disp_ext[DATA_W-1:0] = disp_q;
    cur_nibble           = 4'h0;
    cur_blank            = 1'b0;
    cur_dp               = 1'b0;
    an_hot               = '0;
    upper_zero           = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (disp_ext[4*i +: 4] == 4'h0);
      if (idx_q == IDX_W'(i)) begin
        cur_nibble = disp_ext[4*i +: 4];
        cur_blank  = blank_lz && (i != 0) && upper_zero;
        cur_dp     = dp_in[i];
        an_hot[i]  = 1'b1;
      end
    end
  end

  hex_seg_decode u_decode (
    .nibble (cur_nibble),
    .seg    (glyph)
  );

  always_comb begin
    seg_d = (cur_blank ? SEG_OFF : glyph) ^ SEG_POL;
    dp_d  = cur_dp ^ ACTIVE_LOW;
    an_d  = an_hot ^ AN_POL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pending_q    <= '0;
      disp_q       <= '0;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_OFF ^ SEG_POL;
      dp_q         <= ACTIVE_LOW;
      an_q         <= AN_POL;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      disp_q       <= disp_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
